// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_pkg
// Description : Shared defaults and helpers for the FIFO drain block.
//               WD_DEFAULT      - data word width
//               PKT_LEN_DEFAULT - words per output packet
//               CW_DEFAULT      - delivered-word counter width
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

  localparam int WD_DEFAULT      = 16;
  localparam int PKT_LEN_DEFAULT = 8;
  localparam int CW_DEFAULT      = 16;

  // Width of the in-packet word counter. A single-word packet still needs a
  // 1-bit counter so that the vector is never zero width.
  function automatic int wc_width(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry output buffer holding words captured from the FIFO
//               until the downstream side accepts them.
// Ports       : clk   - clock (rising edge)
//               rst_n - asynchronous active-low reset
//               wr    - write wdat to the tail this cycle
//               wdat  - write data
//               rd    - pop the head this cycle (only while occ != 0)
//               hdat  - head data
//               occ   - occupancy, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2
  import fifo_drain_pkg::*;
#(
  parameter int WD = WD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [WD-1:0] wdat,
  input  logic          rd,
  output logic [WD-1:0] hdat,
  output logic [1:0]    occ
);

  logic [WD-1:0] mem [2];
  logic          wptr;
  logic          rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (wr) wptr <= ~wptr;
      if (rd) rptr <= ~rptr;
      // A write and a pop in the same cycle leave the occupancy unchanged.
      case ({wr, rd})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while occ != 0.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdat;
  end

  assign hdat = mem[rptr];

endmodule
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Drains a FIFO with a one-cycle read latency into a
//               valid/ready stream, framing words into packets of PKT_LEN.
// Ports       : rclk   - FIFO read clock, all logic on its rising edge
//               rst_n  - asynchronous active-low reset
//               en     - drain enable (gates new reads only)
//               rempty - FIFO empty flag
//               ren    - FIFO read enable
//               rdat   - FIFO read data, valid the cycle after ren
//               ovalid - downstream valid
//               oready - downstream ready
//               odat   - downstream data
//               olast  - last word of a packet, qualified by ovalid
//               ocnt   - words accepted downstream, wraps
//               busy   - read in flight or buffer non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int WD      = WD_DEFAULT,
  parameter int PKT_LEN = PKT_LEN_DEFAULT,
  parameter int CW      = CW_DEFAULT
) (
  input  logic          rclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          rempty,
  output logic          ren,
  input  logic [WD-1:0] rdat,
  output logic          ovalid,
  input  logic          oready,
  output logic [WD-1:0] odat,
  output logic          olast,
  output logic [CW-1:0] ocnt,
  output logic          busy
);

  localparam int             WCW     = wc_width(PKT_LEN);
  localparam logic [WCW-1:0] WC_LAST = WCW'(PKT_LEN - 1);

  logic           inf;
  logic [1:0]     occ;
  logic           xfer;
  logic [WCW-1:0] wc;

  // The in-flight word already owns a buffer slot, so it is counted against
  // capacity; this is what keeps the two-entry buffer from overflowing.
  // rst_n gates the output so no read can be issued while held in reset.
  assign ren    = rst_n & en & ~rempty & ((occ + {1'b0, inf}) < 2'd2);

  assign ovalid = (occ != 2'd0);
  assign xfer   = ovalid & oready;
  assign olast  = ovalid & (wc == WC_LAST);
  assign busy   = inf | ovalid;

  // Read data arrives one cycle after ren; inf marks that cycle.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      inf <= 1'b0;
    end else begin
      inf <= ren;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      wc   <= '0;
      ocnt <= '0;
    end else if (xfer) begin
      wc   <= (wc == WC_LAST) ? '0 : wc + 1'b1;
      ocnt <= ocnt + 1'b1;
    end
  end

  skid_buf2 #(
    .WD (WD)
  ) u_buf (
    .clk   (rclk),
    .rst_n (rst_n),
    .wr    (inf),
    .wdat  (rdat),
    .rd    (xfer),
    .hdat  (odat),
    .occ   (occ)
  );

endmodule
`default_nettype wire
